// File: rtl/simple_reg_slv_pkg.sv
// Shared constants and read-pipeline stage type for simple_if register slaves.
// No logic; sizing helpers only.
package simple_reg_slv_pkg;

  localparam int MAX_RD_LAT         = 8;
  localparam int DEF_DATA_BIT_WIDTH = 8;

  function automatic int unsigned calc_num_regs(input int unsigned addr_bit_width);
    return 32'd1 << addr_bit_width;
  endfunction

  // One read-pipeline stage at the default data width.
  typedef struct packed {
    logic                          vld;
    logic [DEF_DATA_BIT_WIDTH-1:0] dat;
  } rd_stage_t;

endpackage

// File: rtl/simple_if.sv
// Single-cycle address/data bus: one shared address, read request, write request.
// Read results return on rd_data_vld/rd_data; there is no back-pressure.
interface simple_if #(
  parameter int ADDR_BIT_WIDTH = 2,
  parameter int DATA_BIT_WIDTH = 8
);
  logic [ADDR_BIT_WIDTH-1:0] addr;
  logic                      rd_req;
  logic                      wr_req;
  logic [DATA_BIT_WIDTH-1:0] wr_data;
  logic                      rd_data_vld;
  logic [DATA_BIT_WIDTH-1:0] rd_data;

  modport mst_port (output addr, rd_req, wr_req, wr_data, input  rd_data_vld, rd_data);
  modport slv_port (input  addr, rd_req, wr_req, wr_data, output rd_data_vld, rd_data);
endinterface

// File: rtl/simple_reg_slv_rd_dly.sv
// LAT-stage valid+data delay line; latency LAT cycles, full throughput.
// No back-pressure: a valid enters every cycle it is offered; data holds while no valid passes.
module simple_reg_slv_rd_dly
  import simple_reg_slv_pkg::*;
#(
  parameter int LAT    = 1,
  parameter int DATA_W = DEF_DATA_BIT_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              req_vld,
  input  logic [DATA_W-1:0] req_dat,
  output logic              rsp_vld,
  output logic [DATA_W-1:0] rsp_dat
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] dat;
  } stage_t;

  generate
    if (LAT < 1 || LAT > MAX_RD_LAT) begin : g_bad_lat
      $error("simple_reg_slv_rd_dly: LAT must be 1..%0d", MAX_RD_LAT);
    end
  endgenerate

  stage_t stg_q [LAT];

  // Data only advances alongside a valid, so the output word is stable between results.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < LAT; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0].vld <= req_vld;
      if (req_vld) stg_q[0].dat <= req_dat;
      for (int i = 1; i < LAT; i++) begin
        stg_q[i].vld <= stg_q[i-1].vld;
        if (stg_q[i-1].vld) stg_q[i].dat <= stg_q[i-1].dat;
      end
    end
  end

  assign rsp_vld = stg_q[LAT-1].vld;
  assign rsp_dat = stg_q[LAT-1].dat;

endmodule

// File: rtl/simple_reg_slv.sv
// simple_if register-bank slave, 2^ADDR_BIT_WIDTH words; reads return after RD_LAT cycles, no back-pressure.
// Optional SIMPLE_REG_SLV_WR_CNT_EN turns the top address into a read-only saturating write counter.
module simple_reg_slv
  import simple_reg_slv_pkg::*;
#(
  parameter int                        ADDR_BIT_WIDTH = 2,
  parameter int                        DATA_BIT_WIDTH = 8,
  parameter int                        RD_LAT         = 1,
  parameter logic [DATA_BIT_WIDTH-1:0] RST_VAL        = '0
) (
  input  logic i_clk,
  input  logic i_arst_n,
  simple_if.slv_port if_s,
  output logic [calc_num_regs(ADDR_BIT_WIDTH)*DATA_BIT_WIDTH-1:0] o_regs
);

  localparam int unsigned NUM_REGS = calc_num_regs(ADDR_BIT_WIDTH);

  logic [DATA_BIT_WIDTH-1:0] reg_q [NUM_REGS];
  logic [DATA_BIT_WIDTH-1:0] view  [NUM_REGS];
  logic                      rsp_vld;
  logic [DATA_BIT_WIDTH-1:0] rsp_dat;

`ifdef SIMPLE_REG_SLV_WR_CNT_EN
  localparam logic [ADDR_BIT_WIDTH-1:0] CNT_ADDR = ADDR_BIT_WIDTH'(NUM_REGS - 1);

  logic                      wr_acc;
  logic [DATA_BIT_WIDTH-1:0] wr_cnt_q;

  assign wr_acc = if_s.wr_req && (if_s.addr != CNT_ADDR);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) reg_q[i] <= RST_VAL;
    end else if (wr_acc) begin
      reg_q[if_s.addr] <= if_s.wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_cnt_q <= '0;
    end else if (wr_acc && (wr_cnt_q != '1)) begin
      wr_cnt_q <= wr_cnt_q + DATA_BIT_WIDTH'(1);
    end
  end

  // The counter replaces the top register in both the read path and o_regs.
  always_comb begin
    view                 = reg_q;
    view[NUM_REGS-1]     = wr_cnt_q;
  end
`else
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) reg_q[i] <= RST_VAL;
    end else if (if_s.wr_req) begin
      reg_q[if_s.addr] <= if_s.wr_data;
    end
  end

  always_comb view = reg_q;
`endif

  // Reads sample the pre-edge register value, giving read-before-write on a shared address.
  simple_reg_slv_rd_dly #(
    .LAT    (RD_LAT),
    .DATA_W (DATA_BIT_WIDTH)
  ) u_rd_dly (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .req_vld  (if_s.rd_req),
    .req_dat  (view[if_s.addr]),
    .rsp_vld  (rsp_vld),
    .rsp_dat  (rsp_dat)
  );

  assign if_s.rd_data_vld = rsp_vld;
  assign if_s.rd_data     = rsp_dat;

  generate
    for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_oregs
      assign o_regs[k*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = view[k];
    end
  endgenerate

endmodule

// File: tb/tb_simple_reg_slv.sv
// Bench for simple_reg_slv: two instances (RD_LAT 1 and 3) share one stimulus stream
// and are checked every cycle against a register-array/expected-read-queue model.
module tb_simple_reg_slv;

`ifdef SIMPLE_REG_SLV_WR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       rd, wr;
  logic [1:0] addr;
  logic [7:0] wdat;
  logic [31:0] regs_a, regs_b;

  simple_if #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8)) bus_a ();
  simple_if #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8)) bus_b ();

  assign bus_a.addr = addr;  assign bus_a.rd_req = rd;  assign bus_a.wr_req = wr;  assign bus_a.wr_data = wdat;
  assign bus_b.addr = addr;  assign bus_b.rd_req = rd;  assign bus_b.wr_req = wr;  assign bus_b.wr_data = wdat;

  simple_reg_slv #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8), .RD_LAT(1), .RST_VAL(8'h00)) dut_a (
    .i_clk(clk), .i_arst_n(arst_n), .if_s(bus_a.slv_port), .o_regs(regs_a));
  simple_reg_slv #(.ADDR_BIT_WIDTH(2), .DATA_BIT_WIDTH(8), .RD_LAT(3), .RST_VAL(8'h00)) dut_b (
    .i_clk(clk), .i_arst_n(arst_n), .if_s(bus_b.slv_port), .o_regs(regs_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: register contents + pending read results ----------------
  typedef struct { int due; logic [7:0] dat; } exp_t;
  logic [7:0] mem [4];
  exp_t       qa[$], qb[$];
  int         cyc = 0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
      qa.delete();
      qb.delete();
    end else begin
      cyc++;
      if (rd) begin
        qa.push_back('{cyc,     mem[addr]});
        qb.push_back('{cyc + 2, mem[addr]});
      end
      if (wr) begin
        if (CNT_EN) begin
          if (addr != 2'd3) begin
            mem[addr] = wdat;
            if (mem[3] != 8'hFF) mem[3] = mem[3] + 8'd1;
          end
        end else begin
          mem[addr] = wdat;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] log_a[$], log_b[$];

  always @(negedge clk) begin
    logic exp_v;
    exp_v = (qa.size() > 0) && (qa[0].due == cyc);
    chk("vld_a", {31'b0, bus_a.rd_data_vld}, {31'b0, exp_v});
    if (exp_v) begin
      chk("dat_a", {24'b0, bus_a.rd_data}, {24'b0, qa[0].dat});
      void'(qa.pop_front());
    end
    if (bus_a.rd_data_vld === 1'b1) log_a.push_back(bus_a.rd_data);
    chk("oregs_a", regs_a, {mem[3], mem[2], mem[1], mem[0]});

    exp_v = (qb.size() > 0) && (qb[0].due == cyc);
    chk("vld_b", {31'b0, bus_b.rd_data_vld}, {31'b0, exp_v});
    if (exp_v) begin
      chk("dat_b", {24'b0, bus_b.rd_data}, {24'b0, qb[0].dat});
      void'(qb.pop_front());
    end
    if (bus_b.rd_data_vld === 1'b1) log_b.push_back(bus_b.rd_data);
    chk("oregs_b", regs_b, {mem[3], mem[2], mem[1], mem[0]});
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    #1;
    rd = r; wr = w; addr = a; wdat = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  // Literal check of the result 'back' positions before the newest one, both instances.
  task automatic chk_log(input int back, input logic [7:0] exp);
    if (log_a.size() > back) chk("lit_rd_a", {24'b0, log_a[log_a.size()-1-back]}, {24'b0, exp});
    else begin checks++; errors++; $display("FAIL lit_rd_a: result missing, want %h", exp); end
    if (log_b.size() > back) chk("lit_rd_b", {24'b0, log_b[log_b.size()-1-back]}, {24'b0, exp});
    else begin checks++; errors++; $display("FAIL lit_rd_b: result missing, want %h", exp); end
  endtask

  int la, lb, cnt_b;

  initial begin
    rd = 1'b0; wr = 1'b0; addr = 2'd0; wdat = 8'h00;
    #1 arst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 arst_n = 1'b1;
    chk("lit_reset_oregs_a", regs_a, 32'h0);
    chk("lit_reset_oregs_b", regs_b, 32'h0);

    // all four registers read zero after reset
    drive(1, 0, 0, 0); drive(1, 0, 1, 0); drive(1, 0, 2, 0); drive(1, 0, 3, 0);
    idle(5);
    for (int i = 0; i < 4; i++) chk_log(i, 8'h00);

    // write then read next cycle; measure exact latency
    drive(0, 1, 2, 8'hA5);
    drive(1, 0, 2, 8'h00);
    @(posedge clk);
    #1 rd = 1'b0;
    la = 0; lb = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus_a.rd_data_vld === 1'b1 && la == 0) la = k;
      if (bus_b.rd_data_vld === 1'b1 && lb == 0) lb = k;
    end
    chk("lit_lat_a", la, 1);
    chk("lit_lat_b", lb, 3);
    chk_log(0, 8'hA5);

    // back-to-back reads after filling the bank
    drive(0, 1, 0, 8'h10); drive(0, 1, 1, 8'h11); drive(0, 1, 2, 8'h12); drive(0, 1, 3, 8'h13);
    drive(1, 0, 0, 0); drive(1, 0, 1, 0); drive(1, 0, 2, 0); drive(1, 0, 3, 0);
    idle(5);
    chk_log(3, 8'h10); chk_log(2, 8'h11); chk_log(1, 8'h12);
    chk_log(0, CNT_EN ? 8'h04 : 8'h13);
    chk("lit_oregs_a", regs_a, CNT_EN ? 32'h04121110 : 32'h13121110);
    chk("lit_oregs_b", regs_b, CNT_EN ? 32'h04121110 : 32'h13121110);

    // read-before-write on the same address
    drive(0, 1, 1, 8'h33);
    drive(1, 1, 1, 8'h44);
    drive(1, 0, 1, 8'h00);
    idle(5);
    chk_log(1, 8'h33);
    chk_log(0, 8'h44);

    // top address: plain register or write counter
    drive(0, 1, 3, 8'h7E);
    drive(1, 0, 3, 8'h00);
    idle(5);
    chk_log(0, CNT_EN ? 8'h06 : 8'h7E);
    chk("lit_oregs_top_a", {24'b0, regs_a[31:24]}, CNT_EN ? 32'h06 : 32'h7E);

    // reset one cycle after two reads: no late results
    cnt_b = 0;
    drive(1, 0, 0, 0);
    drive(1, 0, 1, 0);
    @(negedge clk);
    #1;
    arst_n = 1'b0; rd = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus_b.rd_data_vld !== 1'b0) cnt_b++;
      if (k == 2) #1 arst_n = 1'b1;
    end
    chk("lit_rst_vld_b", cnt_b, 0);
    chk("lit_rst_oregs_a", regs_a, 32'h0);
    chk("lit_rst_oregs_b", regs_b, 32'h0);

    // counter: 5 writes + ignored top write, then saturation
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 8'h20 + 8'(i));
    drive(0, 1, 3, 8'h99);
    drive(1, 0, 3, 8'h00);
    idle(5);
    chk_log(0, CNT_EN ? 8'h05 : 8'h99);
    for (int i = 0; i < 300; i++) drive(0, 1, 0, 8'(i));
    drive(1, 0, 3, 8'h00);
    drive(1, 0, 0, 8'h00);
    idle(5);
    chk_log(1, CNT_EN ? 8'hFF : 8'h99);
    chk_log(0, 8'h2B);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
